// File: rtl/sha_digest_serializer_if.sv
// rtl/sha_digest_serializer_if.sv - byte-stream bundle from the digest serializer to its sink
interface sha_digest_serializer_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [31:0] tid;
  logic [7:0]  tdata;

  modport master (output tvalid, tlast, tid, tdata, input tready);
  modport slave  (input tvalid, tlast, tid, tdata, output tready);
endinterface

// File: rtl/sha_digest_serializer.sv
// rtl/sha_digest_serializer.sv - buffers sha* results and emits them as length+digest byte frames
// SHA_SER_HEX_ASCII_EN: frames emitted as lowercase hex ASCII with a trailing newline.
module sha_digest_serializer #(
  parameter int DIGEST_BITS = 384,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  input  logic [31:0]            iid,
  input  logic [60:0]            ilen,
  input  logic [DIGEST_BITS-1:0] isha,
  sha_digest_serializer_if.master m,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);
  localparam int DIG_BYTES  = DIGEST_BITS / 8;
  localparam int FRAME_BITS = 64 + DIGEST_BITS;
  localparam int ENTRY_BITS = 32 + 61 + DIGEST_BITS;
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(DIG_BYTES);

`ifdef SHA_SER_HEX_ASCII_EN
  typedef enum logic [1:0] {IDLE, LEN, DIG, NL} state_t;
`else
  typedef enum logic [1:0] {IDLE, LEN, DIG} state_t;
`endif

  state_t state, state_next;

  logic [ENTRY_BITS-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [ENTRY_BITS-1:0] rd_entry;
  logic                  full, empty, pop, push, drop;

  logic [FRAME_BITS-1:0] sr;
  logic [CW-1:0]         cnt;
  logic [31:0]           tid_q;
  logic                  busy, hs, adv, len_done, dig_done;
  logic [7:0]            byte_out;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = (state == IDLE) && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign push     = ivalid && (!full || pop);
  assign drop     = ivalid && full && !pop;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {iid, ilen, isha};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= drop;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign hs       = busy && m.tready;
  assign len_done = (cnt == CW'(7));
  assign dig_done = (cnt == CW'(DIG_BYTES - 1));

`ifdef SHA_SER_HEX_ASCII_EN
  logic nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // A frame byte is complete only after its low-nibble character is accepted.
  assign adv      = hs && nib && (state != NL);
  assign byte_out = hex_char(nib ? sr[FRAME_BITS-5 -: 4] : sr[FRAME_BITS-1 -: 4]);
`else
  assign adv      = hs;
  assign byte_out = sr[FRAME_BITS-1 -: 8];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    m.tlast    = 1'b0;
    m.tdata    = 8'h00;
    case (state)
      IDLE: if (pop) state_next = LEN;
      LEN: begin
        m.tdata = byte_out;
        if (adv && len_done) state_next = DIG;
      end
      DIG: begin
        m.tdata = byte_out;
`ifdef SHA_SER_HEX_ASCII_EN
        if (adv && dig_done) state_next = NL;
`else
        m.tlast = dig_done;
        if (adv && dig_done) state_next = IDLE;
`endif
      end
`ifdef SHA_SER_HEX_ASCII_EN
      NL: begin
        m.tdata = 8'h0A;
        m.tlast = 1'b1;
        if (hs) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      tid_q <= '0;
`ifdef SHA_SER_HEX_ASCII_EN
      nib   <= 1'b0;
`endif
    end else if (pop) begin
      sr    <= {3'b000, rd_entry[DIGEST_BITS +: 61], rd_entry[DIGEST_BITS-1:0]};
      cnt   <= '0;
      tid_q <= rd_entry[ENTRY_BITS-1 -: 32];
`ifdef SHA_SER_HEX_ASCII_EN
      nib   <= 1'b0;
`endif
    end else if (hs) begin
      tid_q <= '0;
`ifdef SHA_SER_HEX_ASCII_EN
      nib   <= !nib;
`endif
      if (adv) begin
        sr  <= sr << 8;
        cnt <= (state == LEN && len_done) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign m.tvalid = busy;
  assign m.tid    = tid_q;
endmodule

// File: tb/tb_sha_digest_serializer.sv
// tb/tb_sha_digest_serializer.sv - scoreboard bench for sha_digest_serializer
`timescale 1ns/1ps
module tb_sha_digest_serializer;
  localparam int DB = 384;
  localparam logic [DB-1:0] ABC_SHA =
    384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7;

  logic          clk = 1'b0;
  logic          rst;
  logic          ivalid;
  logic [31:0]   iid;
  logic [60:0]   ilen;
  logic [DB-1:0] isha;
  logic          overflow;
  logic [15:0]   drop_cnt;

  sha_digest_serializer_if m ();

  sha_digest_serializer #(.DIGEST_BITS(DB), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ivalid   (ivalid),
    .iid      (iid),
    .ilen     (ilen),
    .isha     (isha),
    .m        (m),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [31:0] id;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          checks = 0;
  int          failures = 0;
  int          hs_cnt = 0;
  int          ovf_cnt = 0;
  bit          rnd_mode = 0;
  bit          stall_prev = 0;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [31:0] prev_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string hx;
    hx = "0123456789abcdef";
    return hx[n];
  endfunction

  function automatic logic [DB-1:0] mk_sha(input int seed);
    logic [DB-1:0] s;
    for (int k = 0; k < DB / 32; k++)
      s[32*k +: 32] = seed * 32'h9e3779b1 + k * 32'h01000193 + 32'h5a5a0f0f;
    return s;
  endfunction

  task automatic push_frame(input logic [31:0] id, input logic [60:0] len, input logic [DB-1:0] sha);
    logic [DB+63:0] f;
    logic [7:0]     b;
    exp_t           e;
    int             n;
    f = {3'b000, len, sha};
    n = (DB + 64) / 8;
    for (int i = 0; i < n; i++) begin
      b = f[DB+63-8*i -: 8];
`ifdef SHA_SER_HEX_ASCII_EN
      e.data = hexc(b[7:4]); e.last = 1'b0; e.id = (i == 0) ? id : 32'd0;
      sb.push_back(e);
      e.data = hexc(b[3:0]); e.id = 32'd0;
      sb.push_back(e);
`else
      e.data = b; e.last = (i == n - 1); e.id = (i == 0) ? id : 32'd0;
      sb.push_back(e);
`endif
    end
`ifdef SHA_SER_HEX_ASCII_EN
    e.data = 8'h0A; e.last = 1'b1; e.id = 32'd0;
    sb.push_back(e);
`endif
  endtask

  task automatic drive(input logic [31:0] id, input logic [60:0] len, input logic [DB-1:0] sha);
    ivalid = 1'b1; iid = id; ilen = len; isha = sha;
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m.tvalid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check(tag, {62'd0, m.tvalid, sb.size() != 0}, 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_mode) m.tready = ($urandom_range(0, 9) >= 2);
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", {63'd0, m.tvalid}, 64'd1);
        check("stall_tdata", {56'd0, m.tdata}, {56'd0, prev_data});
        check("stall_tlast", {63'd0, m.tlast}, {63'd0, prev_last});
        check("stall_tid", {32'd0, m.tid}, {32'd0, prev_id});
      end
      if (overflow) ovf_cnt++;
      if (m.tvalid && m.tready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_byte", 64'd1, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          check("tdata", {56'd0, m.tdata}, {56'd0, e_mon.data});
          check("tlast", {63'd0, m.tlast}, {63'd0, e_mon.last});
          check("tid", {32'd0, m.tid}, {32'd0, e_mon.id});
        end
      end
      stall_prev = m.tvalid && !m.tready;
      prev_data  = m.tdata;
      prev_last  = m.tlast;
      prev_id    = m.tid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ovf_base;
    int base;
    rst = 1'b1; ivalid = 1'b0; iid = '0; ilen = '0; isha = '0; m.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {63'd0, m.tvalid}, 64'd0);
    check("rst_tlast", {63'd0, m.tlast}, 64'd0);
    check("rst_tid", {32'd0, m.tid}, 64'd0);
    check("rst_tdata", {56'd0, m.tdata}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    rst = 1'b0;

    // abc digest, sink always ready; first byte right after the pop edge
    m.tready = 1'b1;
    push_frame(32'd111, 61'd3, ABC_SHA);
    drive(32'd111, 61'd3, ABC_SHA);
    check("lat_e0_tvalid", {63'd0, m.tvalid}, 64'd0);
    @(posedge clk); #1;
    check("lat_e1_tvalid", {63'd0, m.tvalid}, 64'd1);
    check("lat_e1_tid", {32'd0, m.tid}, 64'd111);
    wait_drain("drain_abc");

    // same input with a randomly stalling sink
    rnd_mode = 1'b1;
    push_frame(32'd111, 61'd3, ABC_SHA);
    drive(32'd111, 61'd3, ABC_SHA);
    wait_drain("drain_abc_rnd");
    rnd_mode = 1'b0;
    @(posedge clk); #1;

    // overflow: four back-to-back results into a blocked sink
    m.tready = 1'b0;
    ovf_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      ivalid = 1'b1; iid = i; ilen = 61'(i * 5); isha = mk_sha(i);
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    for (int i = 1; i <= 3; i++) push_frame(i, 61'(i * 5), mk_sha(i));
    repeat (3) begin @(posedge clk); #1; end
    check("ovf_pulses", ovf_cnt, 64'd1);
    check("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    m.tready = 1'b1;
    wait_drain("drain_ovf");

    // push on the same edge as an IDLE pop while the FIFO is full
    m.tready = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      ivalid = 1'b1; iid = i; ilen = 61'(i); isha = mk_sha(i);
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    for (int i = 10; i <= 13; i++) push_frame(i, 61'(i), mk_sha(i));
    ovf_base = ovf_cnt;
    m.tready = 1'b1;
    n = 0;
    while (!(m.tvalid && m.tlast) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_tlast_timeout", {63'd0, n >= 400}, 64'd0);
    @(posedge clk); #1;
    check("bubble_tvalid", {63'd0, m.tvalid}, 64'd0);
    ivalid = 1'b1; iid = 32'd13; ilen = 61'd13; isha = mk_sha(13);
    @(posedge clk); #1;
    ivalid = 1'b0;
    check("same_edge_overflow", {63'd0, overflow}, 64'd0);
    check("same_edge_tvalid", {63'd0, m.tvalid}, 64'd1);
    @(posedge clk); #1;
    check("same_edge_ovf_cnt", ovf_cnt, ovf_base);
    check("same_edge_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    wait_drain("drain_same_edge");

    // reset while byte 20 of a frame is on the bus
    push_frame(32'd77, 61'd64, mk_sha(77));
    base = hs_cnt;
    drive(32'd77, 61'd64, mk_sha(77));
    n = 0;
    while (hs_cnt < base + 20 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_byte20_timeout", {63'd0, n >= 400}, 64'd0);
    m.tready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_tvalid", {63'd0, m.tvalid}, 64'd0);
    check("midrst_tlast", {63'd0, m.tlast}, 64'd0);
    check("midrst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    m.tready = 1'b1;
    push_frame(32'd78, 61'd1000, mk_sha(78));
    drive(32'd78, 61'd1000, mk_sha(78));
    wait_drain("drain_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
